hdma_controller: RTL and testbench

- CGB VRAM DMA engine (HDMA1-5 at FF51-FF55). It copies 16-byte blocks from ROM/WRAM into the VRAM bank selected by VBK.
- Drives the PPU's DMA-side ports: address_bus_dma_rd/wr, mem_enable_dma_rd/wr, data_in_dma_wr, wr_en_VRAM_bankN_dma_wr, dma_sel_VRAM_bankN.
- Two modes:
  - General-purpose: whole transfer at once, CPU stalled throughout.
  - H-blank: one block per H-blank, scheduled from the PPU's STAT_mode.

---
 rtl/hdma_pkg.sv | 33 +++
 rtl/hdma_byte_mover.sv | 75 +++++++
 rtl/hdma_controller.sv | 165 ++++++++++++++++
 tb/tb_hdma_controller.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdma_pkg.sv
// Shared constants and encodings for the CGB VRAM DMA engine (HDMA1-5).
// Register addresses, PPU mode / VRAM select codes and the FSM encodings live here.
package hdma_pkg;

    localparam int BLOCK_LEN  = 16;
    localparam int BYTE_CNT_W = $clog2(BLOCK_LEN);

    localparam logic [15:0] ADDR_HDMA1 = 16'hFF51;
    localparam logic [15:0] ADDR_HDMA2 = 16'hFF52;
    localparam logic [15:0] ADDR_HDMA3 = 16'hFF53;
    localparam logic [15:0] ADDR_HDMA4 = 16'hFF54;
    localparam logic [15:0] ADDR_HDMA5 = 16'hFF55;

    localparam logic [1:0] STAT_MODE_HBLANK = 2'b00;
    localparam logic [1:0] DMA_SEL_WR       = 2'b10;
    localparam logic [1:0] DMA_SEL_NONE     = 2'b00;

    localparam logic [7:0] HDMA5_DONE = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GDMA,
        ST_HB_WAIT,
        ST_HB_XFER
    } hdma_state_e;

    typedef enum logic [1:0] {
        PH_RD,
        PH_CAP,
        PH_WR
    } byte_phase_e;

endpackage

// File: rtl/hdma_byte_mover.sv
// RD/CAP/WR sequencer that moves one 16-byte block while run_i is held high.
// Latches the VRAM bank at the first RD of each block and flags the last WR.
module hdma_byte_mover
    import hdma_pkg::*;
(
    input  logic       clk4_2,
    input  logic       reset_n,
    input  logic       run_i,
    input  logic       vbk_i,
    input  logic [7:0] rd_data_i,
    output logic       rd_phase_o,
    output logic       wr_phase_o,
    output logic       bank_o,
    output logic [7:0] wr_data_o,
    output logic       block_done_o
);

    byte_phase_e           phase_q, phase_d;
    logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic                  bank_q, bank_d;
    logic [7:0]            data_q, data_d;

    // NOTE: every variable gets its hold value first so no path through the
    // case statement can leave it unassigned and infer a latch.
    always_comb begin
        phase_d    = phase_q;
        byte_cnt_d = byte_cnt_q;
        bank_d     = bank_q;
        data_d     = data_q;
        if (!run_i) begin
            phase_d    = PH_RD;
            byte_cnt_d = '0;
        end else begin
            case (phase_q)
                PH_RD: begin
                    phase_d = PH_CAP;
                    if (byte_cnt_q == '0) bank_d = vbk_i;
                end
                PH_CAP: begin
                    phase_d = PH_WR;
                    data_d  = rd_data_i;
                end
                PH_WR: begin
                    phase_d    = PH_RD;
                    byte_cnt_d = byte_cnt_q + 1'b1;
                end
                default: phase_d = PH_RD;
            endcase
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples
    // the values from before the clock edge, independent of statement order.
    // NOTE: the captured byte is reset too, so the write-data port reads 0 out of reset.
    always_ff @(posedge clk4_2 or negedge reset_n) begin
        if (!reset_n) begin
            phase_q    <= PH_RD;
            byte_cnt_q <= '0;
            bank_q     <= 1'b0;
            data_q     <= '0;
        end else begin
            phase_q    <= phase_d;
            byte_cnt_q <= byte_cnt_d;
            bank_q     <= bank_d;
            data_q     <= data_d;
        end
    end

    assign rd_phase_o   = run_i && (phase_q == PH_RD);
    assign wr_phase_o   = run_i && (phase_q == PH_WR);
    assign bank_o       = bank_q;
    assign wr_data_o    = data_q;
    assign block_done_o = wr_phase_o && (byte_cnt_q == BYTE_CNT_W'(BLOCK_LEN - 1));

endmodule

// File: rtl/hdma_controller.sv
// CGB VRAM DMA controller: FF51-FF55 registers plus the GDMA / H-blank mode FSM.
// Drives the PPU's DMA-side VRAM ports through hdma_byte_mover.
module hdma_controller
    import hdma_pkg::*;
(
    input  logic        clk4_2,
    input  logic        reset_n,
    input  logic [15:0] address_bus_offset,
    input  logic [7:0]  data_in,
    input  logic        mem_we,
    input  logic        VBK,
    input  logic [1:0]  STAT_mode,
    input  logic        LCDC7,
    input  logic [7:0]  data_dma_rd,
    output logic [15:0] address_bus_dma_rd,
    output logic        mem_enable_dma_rd,
    output logic [15:0] address_bus_dma_wr,
    output logic        mem_enable_dma_wr,
    output logic [7:0]  data_in_dma_wr,
    output logic        wr_en_VRAM_bank0_dma_wr,
    output logic        wr_en_VRAM_bank1_dma_wr,
    output logic [1:0]  dma_sel_VRAM_bank0,
    output logic [1:0]  dma_sel_VRAM_bank1,
    output logic        cpu_stall,
    output logic [7:0]  hdma5_rd,
    output logic        hdma_active
);

    hdma_state_e state_q, state_d;
    logic [15:0] src_q, src_d;
    logic [12:0] dst_q, dst_d;
    logic [6:0]  blocks_q, blocks_d;
    logic        cancelled_q, cancelled_d;
    logic        cancel_pend_q, cancel_pend_d;
    logic        prev_hblank_q, prev_hblank_d;

    logic run, rd_phase, wr_phase, bank, block_done;
    logic in_hblank, hb_trigger, hdma5_we, cancel_req;

    assign in_hblank  = (STAT_mode == STAT_MODE_HBLANK);
    assign hb_trigger = !LCDC7 || (in_hblank && !prev_hblank_q);
    assign hdma5_we   = mem_we && (address_bus_offset == ADDR_HDMA5);
    assign cancel_req = hdma5_we && !data_in[7];
    assign run        = (state_q == ST_GDMA) || (state_q == ST_HB_XFER);

    hdma_byte_mover u_mover (
        .clk4_2       (clk4_2),
        .reset_n      (reset_n),
        .run_i        (run),
        .vbk_i        (VBK),
        .rd_data_i    (data_dma_rd),
        .rd_phase_o   (rd_phase),
        .wr_phase_o   (wr_phase),
        .bank_o       (bank),
        .wr_data_o    (data_in_dma_wr),
        .block_done_o (block_done)
    );

    always_comb begin
        state_d       = state_q;
        src_d         = src_q;
        dst_d         = dst_q;
        blocks_d      = blocks_q;
        cancelled_d   = cancelled_q;
        cancel_pend_d = cancel_pend_q;
        prev_hblank_d = in_hblank;

        // Address registers are only writable while idle.
        if (mem_we && state_q == ST_IDLE) begin
            case (address_bus_offset)
                ADDR_HDMA1: src_d[15:8] = data_in;
                ADDR_HDMA2: src_d[7:0]  = {data_in[7:4], 4'h0};
                ADDR_HDMA3: dst_d[12:8] = data_in[4:0];
                ADDR_HDMA4: dst_d[7:0]  = {data_in[7:4], 4'h0};
                default: ;
            endcase
        end

        if (wr_phase) begin
            src_d = src_q + 16'd1;
            dst_d = dst_q + 13'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (hdma5_we) begin
                    blocks_d      = data_in[6:0];
                    cancelled_d   = 1'b0;
                    cancel_pend_d = 1'b0;
                    state_d       = data_in[7] ? ST_HB_WAIT : ST_GDMA;
                end
            end
            ST_GDMA: begin
                if (block_done) begin
                    if (blocks_q == '0) state_d = ST_IDLE;
                    else                blocks_d = blocks_q - 7'd1;
                end
            end
            ST_HB_WAIT: begin
                if (cancel_req) begin
                    cancelled_d = 1'b1;
                    state_d     = ST_IDLE;
                end else if (hb_trigger) begin
                    state_d = ST_HB_XFER;
                end
            end
            ST_HB_XFER: begin
                if (cancel_req) cancel_pend_d = 1'b1;
                // A cancelled block still finishes; the remaining count is left as-is.
                if (block_done) begin
                    cancel_pend_d = 1'b0;
                    if (blocks_q == '0) begin
                        state_d = ST_IDLE;
                    end else if (cancel_pend_q || cancel_req) begin
                        cancelled_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        blocks_d = blocks_q - 7'd1;
                        state_d  = ST_HB_WAIT;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk4_2 or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            src_q         <= '0;
            dst_q         <= '0;
            blocks_q      <= '0;
            cancelled_q   <= 1'b0;
            cancel_pend_q <= 1'b0;
            prev_hblank_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            src_q         <= src_d;
            dst_q         <= dst_d;
            blocks_q      <= blocks_d;
            cancelled_q   <= cancelled_d;
            cancel_pend_q <= cancel_pend_d;
            prev_hblank_q <= prev_hblank_d;
        end
    end

    // Address buses are gated so they read zero outside their own phase.
    assign address_bus_dma_rd      = rd_phase ? src_q : 16'h0000;
    assign mem_enable_dma_rd       = rd_phase;
    assign address_bus_dma_wr      = wr_phase ? {3'b100, dst_q} : 16'h0000;
    assign mem_enable_dma_wr       = wr_phase;
    assign wr_en_VRAM_bank0_dma_wr = wr_phase && !bank;
    assign wr_en_VRAM_bank1_dma_wr = wr_phase && bank;
    assign dma_sel_VRAM_bank0      = wr_en_VRAM_bank0_dma_wr ? DMA_SEL_WR : DMA_SEL_NONE;
    assign dma_sel_VRAM_bank1      = wr_en_VRAM_bank1_dma_wr ? DMA_SEL_WR : DMA_SEL_NONE;
    assign cpu_stall               = run;
    assign hdma_active             = (state_q != ST_IDLE);

    always_comb begin
        hdma5_rd = HDMA5_DONE;
        if (state_q != ST_IDLE) hdma5_rd = {1'b0, blocks_q};
        else if (cancelled_q)   hdma5_rd = {1'b1, blocks_q};
    end

endmodule

// File: tb/tb_hdma_controller.sv
// Self-checking bench for hdma_controller: random source memory, VRAM write log,
// and expected copies computed from src/dst/block arithmetic.
module tb_hdma_controller;

    logic        clk4_2;
    logic        reset_n;
    logic [15:0] address_bus_offset;
    logic [7:0]  data_in;
    logic        mem_we;
    logic        VBK;
    logic [1:0]  STAT_mode;
    logic        LCDC7;
    logic [7:0]  data_dma_rd;
    logic [15:0] address_bus_dma_rd;
    logic        mem_enable_dma_rd;
    logic [15:0] address_bus_dma_wr;
    logic        mem_enable_dma_wr;
    logic [7:0]  data_in_dma_wr;
    logic        wr_en_VRAM_bank0_dma_wr;
    logic        wr_en_VRAM_bank1_dma_wr;
    logic [1:0]  dma_sel_VRAM_bank0;
    logic [1:0]  dma_sel_VRAM_bank1;
    logic        cpu_stall;
    logic [7:0]  hdma5_rd;
    logic        hdma_active;

    hdma_controller dut (
        .clk4_2                  (clk4_2),
        .reset_n                 (reset_n),
        .address_bus_offset      (address_bus_offset),
        .data_in                 (data_in),
        .mem_we                  (mem_we),
        .VBK                     (VBK),
        .STAT_mode               (STAT_mode),
        .LCDC7                   (LCDC7),
        .data_dma_rd             (data_dma_rd),
        .address_bus_dma_rd      (address_bus_dma_rd),
        .mem_enable_dma_rd       (mem_enable_dma_rd),
        .address_bus_dma_wr      (address_bus_dma_wr),
        .mem_enable_dma_wr       (mem_enable_dma_wr),
        .data_in_dma_wr          (data_in_dma_wr),
        .wr_en_VRAM_bank0_dma_wr (wr_en_VRAM_bank0_dma_wr),
        .wr_en_VRAM_bank1_dma_wr (wr_en_VRAM_bank1_dma_wr),
        .dma_sel_VRAM_bank0      (dma_sel_VRAM_bank0),
        .dma_sel_VRAM_bank1      (dma_sel_VRAM_bank1),
        .cpu_stall               (cpu_stall),
        .hdma5_rd                (hdma5_rd),
        .hdma_active             (hdma_active)
    );

    typedef struct {
        logic        bank;
        logic [15:0] addr;
        logic [7:0]  data;
        int          cyc;
    } wr_t;

    logic [7:0] src_mem [0:65535];
    wr_t        wr_log [$];
    int         cycle      = 0;
    int         stall_cnt  = 0;
    int         proto_err  = 0;
    int         tests_run  = 0;
    int         tests_failed = 0;
    bit         rd_pend    = 0;
    logic [15:0] rd_addr   = '0;

    initial clk4_2 = 1'b0;
    always #5 clk4_2 = ~clk4_2;

    // Source memory: read data shows up only in the cycle after the enable, junk otherwise.
    always @(negedge clk4_2) begin
        if (rd_pend) data_dma_rd = src_mem[rd_addr];
        else         data_dma_rd = 8'($urandom);
        rd_pend = mem_enable_dma_rd;
        rd_addr = address_bus_dma_rd;
    end

    // VRAM side monitor: logs every strobed write and tracks port consistency.
    always @(negedge clk4_2) begin
        cycle++;
        if (cpu_stall) stall_cnt++;
        if (wr_en_VRAM_bank0_dma_wr || wr_en_VRAM_bank1_dma_wr)
            wr_log.push_back('{bank: wr_en_VRAM_bank1_dma_wr, addr: address_bus_dma_wr,
                               data: data_in_dma_wr, cyc: cycle});
        if (wr_en_VRAM_bank0_dma_wr && wr_en_VRAM_bank1_dma_wr) proto_err++;
        if (dma_sel_VRAM_bank0 !== (wr_en_VRAM_bank0_dma_wr ? 2'b10 : 2'b00)) proto_err++;
        if (dma_sel_VRAM_bank1 !== (wr_en_VRAM_bank1_dma_wr ? 2'b10 : 2'b00)) proto_err++;
        if (mem_enable_dma_wr !== (wr_en_VRAM_bank0_dma_wr | wr_en_VRAM_bank1_dma_wr)) proto_err++;
    end

    // Reference: byte i of a transfer goes to VRAM {100, dst+i mod 8K} from src+i mod 64K.
    function automatic int count_bad(input int s, input int n, input logic [15:0] src,
                                     input logic [12:0] dst, input logic bank);
        int          bad;
        logic [12:0] d;
        logic [15:0] a;
        wr_t         e;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            if (s + i >= wr_log.size()) begin
                bad++;
            end else begin
                e = wr_log[s + i];
                d = dst + 13'(i);
                a = src + 16'(i);
                if (e.bank !== bank || e.addr !== {3'b100, d} || e.data !== src_mem[a]) bad++;
            end
        end
        return bad;
    endfunction

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk4_2);
        address_bus_offset = a;
        data_in            = d;
        mem_we             = 1'b1;
        @(negedge clk4_2);
        mem_we             = 1'b0;
    endtask

    task automatic set_regs(input logic [15:0] src, input logic [12:0] dst);
        cpu_write(16'hFF51, src[15:8]);
        cpu_write(16'hFF52, src[7:0]);
        cpu_write(16'hFF53, {3'($urandom), dst[12:8]});
        cpu_write(16'hFF54, dst[7:0]);
    endtask

    task automatic wait_idle(input int max_cyc, output bit ok);
        ok = 0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk4_2);
            if (!hdma_active) begin
                ok = 1;
                break;
            end
        end
        repeat (2) @(negedge clk4_2);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk4_2);
        tests_run++;
        if (hdma5_rd !== 8'hFF) begin
            tests_failed++; $display("FAIL reset_hdma5: got %0h expected ff", hdma5_rd);
        end
        tests_run++;
        if ({hdma_active, cpu_stall} !== 2'b00) begin
            tests_failed++; $display("FAIL reset_active_stall: got %0b expected 00", {hdma_active, cpu_stall});
        end
        tests_run++;
        if ({mem_enable_dma_rd, mem_enable_dma_wr, wr_en_VRAM_bank0_dma_wr, wr_en_VRAM_bank1_dma_wr} !== 4'b0) begin
            tests_failed++; $display("FAIL reset_strobes: got %0b expected 0",
                {mem_enable_dma_rd, mem_enable_dma_wr, wr_en_VRAM_bank0_dma_wr, wr_en_VRAM_bank1_dma_wr});
        end
        tests_run++;
        if ({address_bus_dma_rd, address_bus_dma_wr, data_in_dma_wr, dma_sel_VRAM_bank0, dma_sel_VRAM_bank1} !== 44'h0) begin
            tests_failed++; $display("FAIL reset_buses: got %0h expected 0",
                {address_bus_dma_rd, address_bus_dma_wr, data_in_dma_wr, dma_sel_VRAM_bank0, dma_sel_VRAM_bank1});
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk4_2);
        tests_run++;
        if (hdma5_rd !== 8'hFF || hdma_active !== 1'b0) begin
            tests_failed++; $display("FAIL post_reset_idle: got hdma5=%0h active=%0b expected ff/0", hdma5_rd, hdma_active);
        end
    endtask

    task automatic test_gdma_one_block();
        int s, st0;
        bit ok;
        VBK = 1'b0;
        set_regs(16'hC000, 13'h0000);
        s   = wr_log.size();
        st0 = stall_cnt;
        cpu_write(16'hFF55, 8'h00);
        wait_idle(200, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL gdma1_timeout: got active expected idle"); end
        tests_run++;
        if (wr_log.size() - s != 16) begin
            tests_failed++; $display("FAIL gdma1_count: got %0d expected 16", wr_log.size() - s);
        end
        tests_run++;
        if (count_bad(s, 16, 16'hC000, 13'h0, 1'b0) != 0) begin
            tests_failed++; $display("FAIL gdma1_data: got %0d bad bytes expected 0", count_bad(s, 16, 16'hC000, 13'h0, 1'b0));
        end
        tests_run++;
        if (stall_cnt - st0 != 48) begin
            tests_failed++; $display("FAIL gdma1_stall: got %0d expected 48", stall_cnt - st0);
        end
        tests_run++;
        if (hdma5_rd !== 8'hFF) begin
            tests_failed++; $display("FAIL gdma1_hdma5: got %0h expected ff", hdma5_rd);
        end
    endtask

    task automatic test_hblank_blocks();
        int          s;
        logic [15:0] src;
        logic [12:0] dst;
        logic        bank;
        src = 16'($urandom) & 16'hFFF0;
        dst = 13'($urandom) & 13'h1FF0;
        bank = 1'($urandom);
        VBK = bank; LCDC7 = 1'b1; STAT_mode = 2'b10;
        set_regs(src, dst);
        s = wr_log.size();
        cpu_write(16'hFF55, 8'h82);
        for (int k = 0; k < 3; k++) begin
            STAT_mode = 2'b10;
            repeat (5) @(negedge clk4_2);
            STAT_mode = 2'b11;
            repeat (10) @(negedge clk4_2);
            tests_run++;
            if (wr_log.size() - s != 16 * k) begin
                tests_failed++; $display("FAIL hb_no_xfer_outside_hblank: got %0d bytes expected %0d", wr_log.size() - s, 16 * k);
            end
            tests_run++;
            if (hdma5_rd !== 8'(2 - k) || hdma_active !== 1'b1) begin
                tests_failed++; $display("FAIL hb_hdma5_progress: got %0h active=%0b expected %0h/1", hdma5_rd, hdma_active, 8'(2 - k));
            end
            STAT_mode = 2'b00;
            repeat (60) @(negedge clk4_2);
            tests_run++;
            if (wr_log.size() - s != 16 * (k + 1)) begin
                tests_failed++; $display("FAIL hb_block_per_edge: got %0d bytes expected %0d", wr_log.size() - s, 16 * (k + 1));
            end
        end
        STAT_mode = 2'b10;
        repeat (2) @(negedge clk4_2);
        tests_run++;
        if (hdma5_rd !== 8'hFF || hdma_active !== 1'b0) begin
            tests_failed++; $display("FAIL hb_done: got %0h active=%0b expected ff/0", hdma5_rd, hdma_active);
        end
        tests_run++;
        if (count_bad(s, 48, src, dst, bank) != 0) begin
            tests_failed++; $display("FAIL hb_data: got %0d bad bytes expected 0", count_bad(s, 48, src, dst, bank));
        end
    endtask

    task automatic test_cancel();
        int          s, s_end;
        bit          ok;
        logic [15:0] src;
        logic [12:0] dst;
        logic        bank;
        src = 16'($urandom) & 16'hFFF0;
        dst = 13'($urandom) & 13'h1FF0;
        bank = 1'($urandom);
        VBK = bank; LCDC7 = 1'b1; STAT_mode = 2'b10;
        set_regs(src, dst);
        s = wr_log.size();
        cpu_write(16'hFF55, 8'h85);
        STAT_mode = 2'b00;
        repeat (60) @(negedge clk4_2);
        STAT_mode = 2'b11;
        cpu_write(16'hFF55, 8'hFF);
        cpu_write(16'hFF51, ~src[15:8]);
        tests_run++;
        if (hdma5_rd !== 8'h04 || hdma_active !== 1'b1) begin
            tests_failed++; $display("FAIL cancel_ignored_writes: got %0h active=%0b expected 04/1", hdma5_rd, hdma_active);
        end
        repeat (5) @(negedge clk4_2);
        STAT_mode = 2'b00;
        repeat (20) @(negedge clk4_2);
        cpu_write(16'hFF55, 8'h00);
        wait_idle(100, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL cancel_timeout: got active expected idle"); end
        tests_run++;
        if (wr_log.size() - s != 32) begin
            tests_failed++; $display("FAIL cancel_count: got %0d expected 32", wr_log.size() - s);
        end
        tests_run++;
        if (count_bad(s, 32, src, dst, bank) != 0) begin
            tests_failed++; $display("FAIL cancel_data: got %0d bad bytes expected 0", count_bad(s, 32, src, dst, bank));
        end
        tests_run++;
        if (hdma5_rd !== 8'h84 || hdma_active !== 1'b0) begin
            tests_failed++; $display("FAIL cancel_hdma5: got %0h active=%0b expected 84/0", hdma5_rd, hdma_active);
        end
        s_end = wr_log.size();
        STAT_mode = 2'b10;
        repeat (5) @(negedge clk4_2);
        STAT_mode = 2'b00;
        repeat (60) @(negedge clk4_2);
        tests_run++;
        if (wr_log.size() != s_end) begin
            tests_failed++; $display("FAIL cancel_stays_idle: got %0d extra bytes expected 0", wr_log.size() - s_end);
        end
        STAT_mode = 2'b10;
    endtask

    task automatic test_bank_wrap();
        int          s;
        bit          ok;
        logic [15:0] src;
        src = 16'($urandom) & 16'hFFF0;
        VBK = 1'b1;
        set_regs(src, 13'h1FF0);
        s = wr_log.size();
        cpu_write(16'hFF55, 8'h01);
        wait_idle(300, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL wrap_timeout: got active expected idle"); end
        tests_run++;
        if (wr_log.size() - s != 32) begin
            tests_failed++; $display("FAIL wrap_count: got %0d expected 32", wr_log.size() - s);
        end
        tests_run++;
        if (count_bad(s, 32, src, 13'h1FF0, 1'b1) != 0) begin
            tests_failed++; $display("FAIL wrap_bank1_data: got %0d bad bytes expected 0", count_bad(s, 32, src, 13'h1FF0, 1'b1));
        end
        tests_run++;
        if (wr_log.size() < s + 17 || wr_log[s + 16].addr !== 16'h8000) begin
            tests_failed++; $display("FAIL wrap_second_block_addr: got %0h expected 8000",
                (wr_log.size() >= s + 17) ? wr_log[s + 16].addr : 16'hxxxx);
        end
        VBK = 1'b0;
    endtask

    task automatic test_lcd_off();
        int          s, gap;
        bit          ok;
        logic [15:0] src;
        logic [12:0] dst;
        src = 16'($urandom) & 16'hFFF0;
        dst = 13'($urandom) & 13'h1FF0;
        VBK = 1'b0; LCDC7 = 1'b0; STAT_mode = 2'b10;
        set_regs(src, dst);
        s = wr_log.size();
        cpu_write(16'hFF55, 8'h81);
        wait_idle(300, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL lcdoff_timeout: got active expected idle"); end
        tests_run++;
        if (wr_log.size() - s != 32 || count_bad(s, 32, src, dst, 1'b0) != 0) begin
            tests_failed++; $display("FAIL lcdoff_data: got %0d bytes expected 32 correct", wr_log.size() - s);
        end
        gap = (wr_log.size() >= s + 17) ? wr_log[s + 16].cyc - wr_log[s + 15].cyc : 999;
        tests_run++;
        if (gap > 4) begin
            tests_failed++; $display("FAIL lcdoff_gap: got %0d cycles between blocks expected <= 4", gap);
        end
        LCDC7 = 1'b1;
    endtask

    task automatic test_random_gdma();
        int          s, st0, n;
        bit          ok;
        logic [15:0] src;
        logic [12:0] dst;
        logic        bank;
        for (int it = 0; it < 4; it++) begin
            src  = 16'($urandom) & 16'hFFF0;
            dst  = 13'($urandom) & 13'h1FF0;
            bank = 1'($urandom);
            n    = $urandom_range(0, 3);
            VBK  = bank;
            set_regs(src, dst);
            s   = wr_log.size();
            st0 = stall_cnt;
            cpu_write(16'hFF55, 8'(n));
            wait_idle(400, ok);
            tests_run++;
            if (!ok || wr_log.size() - s != 16 * (n + 1) || count_bad(s, 16 * (n + 1), src, dst, bank) != 0) begin
                tests_failed++; $display("FAIL rand_gdma_data: got %0d bytes expected %0d correct (src %0h dst %0h)",
                    wr_log.size() - s, 16 * (n + 1), src, dst);
            end
            tests_run++;
            if (stall_cnt - st0 != 48 * (n + 1)) begin
                tests_failed++; $display("FAIL rand_gdma_stall: got %0d expected %0d", stall_cnt - st0, 48 * (n + 1));
            end
        end
        VBK = 1'b0;
    endtask

    task automatic test_reset_mid_gdma();
        int s, s2, seen;
        bit found, ok;
        VBK = 1'b0;
        set_regs(16'($urandom) & 16'hFFF0, 13'($urandom) & 13'h1FF0);
        s = wr_log.size();
        cpu_write(16'hFF55, 8'h01);
        seen = 0; found = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk4_2);
            if (mem_enable_dma_wr) seen++;
            if (seen == 5) begin found = 1; break; end
        end
        tests_run++;
        if (!found) begin tests_failed++; $display("FAIL rst_mid_find_wr5: got %0d writes expected 5", seen); end
        #1 reset_n = 1'b0;
        #1;
        tests_run++;
        if ({mem_enable_dma_wr, wr_en_VRAM_bank0_dma_wr, wr_en_VRAM_bank1_dma_wr, mem_enable_dma_rd, cpu_stall} !== 5'b0) begin
            tests_failed++; $display("FAIL rst_mid_strobes: got %0b expected 0",
                {mem_enable_dma_wr, wr_en_VRAM_bank0_dma_wr, wr_en_VRAM_bank1_dma_wr, mem_enable_dma_rd, cpu_stall});
        end
        tests_run++;
        if (hdma5_rd !== 8'hFF || hdma_active !== 1'b0) begin
            tests_failed++; $display("FAIL rst_mid_status: got %0h active=%0b expected ff/0", hdma5_rd, hdma_active);
        end
        repeat (2) @(negedge clk4_2);
        reset_n = 1'b1;
        @(negedge clk4_2);
        tests_run++;
        if (wr_log.size() - s != 5) begin
            tests_failed++; $display("FAIL rst_mid_no_more_writes: got %0d expected 5", wr_log.size() - s);
        end
        cpu_write(16'hFF51, 8'hAB);
        cpu_write(16'hFF52, 8'hC7);
        s2 = wr_log.size();
        cpu_write(16'hFF55, 8'h00);
        wait_idle(200, ok);
        tests_run++;
        if (!ok || count_bad(s2, 16, 16'hABC0, 13'h0, 1'b0) != 0 || wr_log.size() - s2 != 16) begin
            tests_failed++; $display("FAIL rst_mid_regs_after_release: got %0d bytes expected 16 from abc0 to 8000",
                wr_log.size() - s2);
        end
    endtask

    task automatic test_protocol();
        tests_run++;
        if (proto_err != 0) begin
            tests_failed++; $display("FAIL port_consistency: got %0d violations expected 0", proto_err);
        end
    endtask

    initial begin
        reset_n            = 1'b0;
        mem_we             = 1'b0;
        address_bus_offset = '0;
        data_in            = '0;
        VBK                = 1'b0;
        STAT_mode          = 2'b10;
        LCDC7              = 1'b1;
        for (int i = 0; i < 65536; i++) src_mem[i] = 8'($urandom);

        test_reset();
        test_gdma_one_block();
        test_hblank_blocks();
        test_cancel();
        test_bank_wrap();
        test_lcd_off();
        test_random_gdma();
        test_reset_mid_gdma();
        test_protocol();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
